// File: rtl/ps2_keyboard_tx.sv
// ps2_keyboard_tx
//
// Device-side PS/2 keyboard transmitter. Scan codes arrive on a parallel
// strobe interface, are buffered in a small FIFO and are sent one at a time
// as 11-bit PS/2 frames: start 0, eight data bits LSB first, odd parity,
// stop 1. Lines are driven push-pull; host-to-device traffic is not handled.
//
// Parameters
//   HALF   system clocks per PS/2 clock half-period (2..65535)
//   GAP    idle clocks with both lines high between frames (1..65535)
//   DEPTH  FIFO entries, power of two (2..16)
//
// Ports
//   i_clk       system clock, rising edge
//   i_clr_n     synchronous active-low reset
//   i_data      scan code to enqueue
//   i_valid     enqueue strobe, one code per cycle
//   o_ps2_clk   PS/2 clock, idles high
//   o_ps2_data  PS/2 data, idles high
//   o_full      FIFO holds DEPTH codes
//   o_overflow  sticky flag: a code was dropped because the FIFO was full
//   o_count     FIFO occupancy
//   o_busy      frame in progress, FSM not idle, or FIFO non-empty

module ps2_keyboard_tx #(
    parameter int HALF  = 4,
    parameter int GAP   = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_clr_n,
    input  logic [7:0]               i_data,
    input  logic                     i_valid,
    output logic                     o_ps2_clk,
    output logic                     o_ps2_data,
    output logic                     o_full,
    output logic                     o_overflow,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_next;
    logic [7:0]    head;
    logic          wr_en;
    logic          pop;
    logic [9:0]    shifter;
    logic [3:0]    bit_idx;
    logic [15:0]   timer;

    // Full is judged on the registered flag, so a write arriving on the
    // same edge as a pop from a full FIFO is still dropped.
    assign wr_en = i_valid && !o_full;
    assign pop   = (state == S_IDLE) && (o_count != '0);
    assign head  = mem[rd_ptr];

    always_comb begin
        count_next = o_count;
        if (wr_en && !pop) begin
            count_next = o_count + 1'b1;
        end else if (!wr_en && pop) begin
            count_next = o_count - 1'b1;
        end
    end

    // Storage array; no reset needed since the pointers define validity.
    always_ff @(posedge i_clk) begin
        if (i_clr_n && wr_en) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_count    <= '0;
            o_full     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            o_count <= count_next;
            o_full  <= (count_next == FULL_CNT);
            if (i_valid && o_full) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Frame serialiser. The start bit goes out on the pop edge; each later
    // bit is shifted out on the edge that begins a HIGH phase, so data is
    // stable for HALF cycles either side of every falling clock edge.
    // o_busy only drops on edges that land in IDLE with nothing queued.
    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            state      <= S_IDLE;
            o_ps2_clk  <= 1'b1;
            o_ps2_data <= 1'b1;
            shifter    <= '0;
            bit_idx    <= '0;
            timer      <= '0;
            o_busy     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state      <= S_HIGH;
                        timer      <= '0;
                        bit_idx    <= '0;
                        o_ps2_data <= 1'b0;
                        shifter    <= {1'b1, ~^head, head};
                        o_busy     <= 1'b1;
                    end else begin
                        o_busy <= (count_next != '0);
                    end
                end
                S_HIGH: begin
                    if (timer == HALF_LAST) begin
                        timer     <= '0;
                        o_ps2_clk <= 1'b0;
                        state     <= S_LOW;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_LOW: begin
                    if (timer == HALF_LAST) begin
                        timer     <= '0;
                        o_ps2_clk <= 1'b1;
                        if (bit_idx < 4'd10) begin
                            bit_idx    <= bit_idx + 1'b1;
                            o_ps2_data <= shifter[0];
                            shifter    <= shifter >> 1;
                            state      <= S_HIGH;
                        end else begin
                            o_ps2_data <= 1'b1;
                            state      <= S_GAP;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_GAP: begin
                    if (timer == GAP_LAST) begin
                        timer  <= '0;
                        state  <= S_IDLE;
                        o_busy <= (count_next != '0);
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// tb_ps2_keyboard_tx
//
// Directed bench for ps2_keyboard_tx with default parameters. Accepted scan
// codes are queued as the bench drives them; a line monitor rebuilds each
// frame from data sampled at PS/2 clock falling edges and compares it with
// the oldest queued code. Directed steps cover reset, latency, parity
// corners, back-to-back spacing, overflow, write-while-full-pop and reset
// in the middle of a frame.

module tb_ps2_keyboard_tx;

    localparam int HALF  = 4;
    localparam int GAP   = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          i_clk   = 1'b0;
    logic          i_clr_n = 1'b0;
    logic [7:0]    i_data  = 8'h00;
    logic          i_valid = 1'b0;
    logic          o_ps2_clk;
    logic          o_ps2_data;
    logic          o_full;
    logic          o_overflow;
    logic [CW-1:0] o_count;
    logic          o_busy;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [7:0]  exp_q[$];
    int          frames_done = 0;
    int          frame_high[64];
    int          frame_gap[64];
    logic [10:0] frame_bits[64];

    ps2_keyboard_tx #(.HALF(HALF), .GAP(GAP), .DEPTH(DEPTH)) dut (
        .i_clk      (i_clk),
        .i_clr_n    (i_clr_n),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ps2_clk  (o_ps2_clk),
        .o_ps2_data (o_ps2_data),
        .o_full     (o_full),
        .o_overflow (o_overflow),
        .o_count    (o_count),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] code, input bit accept);
        i_data  = code;
        i_valid = 1'b1;
        if (accept) exp_q.push_back(code);
        step();
        i_valid = 1'b0;
    endtask

    task automatic waitFrames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            step();
            n++;
        end
        checkOutput("frame_wait", 32'(frames_done >= target), 1);
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (o_busy !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        checkOutput("idle_wait", 32'(o_busy), 0);
    endtask

    // Line monitor, sampled on the falling system clock edge. A 1->0 data
    // transition with the PS/2 clock high marks HIGH entry; the clock rising
    // after the 11th falling edge marks GAP entry and completes the frame.
    logic        prev_clk  = 1'b1;
    logic        prev_data = 1'b1;
    logic        clr_seen  = 1'b0;
    bit          in_frame  = 1'b0;
    int          nbits     = 0;
    logic [10:0] cur_bits  = '0;
    int          cur_high  = 0;
    int          cur_first = 0;
    int          cur_last  = 0;

    always @(negedge i_clk) begin
        logic [7:0] e;
        if (!clr_seen) begin
            in_frame = 1'b0;
            nbits    = 0;
        end else if (!in_frame) begin
            if (prev_data === 1'b1 && o_ps2_data === 1'b0 && o_ps2_clk === 1'b1) begin
                in_frame = 1'b1;
                nbits    = 0;
                cur_high = cyc;
            end
        end else begin
            if (prev_clk === 1'b1 && o_ps2_clk === 1'b0) begin
                if (nbits < 11) cur_bits[nbits[3:0]] = o_ps2_data;
                if (nbits == 0) cur_first = cyc;
                cur_last = cyc;
                nbits++;
            end else if (prev_clk === 1'b0 && o_ps2_clk === 1'b1 && nbits == 11) begin
                checkOutput("first_fall", cur_first - cur_high, HALF);
                checkOutput("last_fall", cur_last - cur_high, 21 * HALF);
                checkOutput("gap_entry", cyc - cur_high, 22 * HALF);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_frame", 32'(cur_bits), 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("frame_bits", 32'(cur_bits), 32'({1'b1, ~^e, e, 1'b0}));
                end
                frame_high[frames_done[5:0]] = cur_high;
                frame_gap[frames_done[5:0]]  = cyc;
                frame_bits[frames_done[5:0]] = cur_bits;
                frames_done++;
                in_frame = 1'b0;
            end
        end
        prev_clk  = o_ps2_clk;
        prev_data = o_ps2_data;
        clr_seen  = i_clr_n;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int t1;
        int g;
        int h;
        logic [7:0] par_codes[4] = '{8'h00, 8'hFF, 8'h01, 8'h80};
        logic       par_exp[4]   = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] b2b_codes[4] = '{8'h1C, 8'hF0, 8'h1C, 8'h5A};
        int         b2b_cnt[4]   = '{1, 1, 2, 3};

        // Reset values
        i_clr_n = 1'b0;
        repeat (3) step();
        checkOutput("rst_clk", 32'(o_ps2_clk), 1);
        checkOutput("rst_data", 32'(o_ps2_data), 1);
        checkOutput("rst_full", 32'(o_full), 0);
        checkOutput("rst_ovf", 32'(o_overflow), 0);
        checkOutput("rst_count", 32'(o_count), 0);
        checkOutput("rst_busy", 32'(o_busy), 0);
        i_clr_n = 1'b1;
        step();

        // Single 0x1C frame: latency, bit pattern, return to idle
        $display("[TB] single frame 0x1C");
        base = frames_done;
        applyStimulus(8'h1C, 1'b1);
        checkOutput("t_busy", 32'(o_busy), 1);
        checkOutput("t_count", 32'(o_count), 1);
        checkOutput("t_data_idle", 32'(o_ps2_data), 1);
        step();
        checkOutput("t1_start", 32'(o_ps2_data), 0);
        checkOutput("t1_clk", 32'(o_ps2_clk), 1);
        checkOutput("t1_count", 32'(o_count), 0);
        t1 = cyc;
        waitFrames(base + 1, 200);
        checkOutput("high_entry", frame_high[base[5:0]], t1);
        checkOutput("bits_1c", 32'(frame_bits[base[5:0]]), 32'h438);
        g = frame_gap[base[5:0]];
        while (cyc < g + GAP - 1) step();
        checkOutput("busy_in_gap", 32'(o_busy), 1);
        checkOutput("gap_clk", 32'(o_ps2_clk), 1);
        checkOutput("gap_data", 32'(o_ps2_data), 1);
        while (cyc < g + GAP + 1) step();
        checkOutput("busy_low", 32'(o_busy), 0);

        // Parity corners
        $display("[TB] parity corners");
        for (int i = 0; i < 4; i++) begin
            base = frames_done;
            applyStimulus(par_codes[i], 1'b1);
            waitFrames(base + 1, 200);
            checkOutput("parity", 32'(frame_bits[base[5:0]][9]), 32'(par_exp[i]));
            checkOutput("stop", 32'(frame_bits[base[5:0]][10]), 1);
            waitIdle(50);
        end

        // Back-to-back writes; the first pop lands on the second write
        $display("[TB] back-to-back");
        base = frames_done;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(b2b_codes[i], 1'b1);
            checkOutput("b2b_count", 32'(o_count), b2b_cnt[i]);
        end
        waitFrames(base + 4, 4 * 120);
        for (int k = 0; k < 3; k++) begin
            checkOutput("b2b_spacing",
                        frame_high[6'(base + k + 1)] - frame_gap[6'(base + k)], GAP + 1);
        end
        waitIdle(50);

        // Overflow while the first frame is in flight
        $display("[TB] overflow");
        base = frames_done;
        applyStimulus(8'h11, 1'b1);
        step();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'(8'h21 + i), i < 4);
            checkOutput("ovf_count", 32'(o_count), (i < 4) ? i + 1 : 4);
            checkOutput("ovf_full", 32'(o_full), (i >= 3) ? 1 : 0);
            checkOutput("ovf_flag", 32'(o_overflow), (i == 4) ? 1 : 0);
        end

        // Write on the same edge as a pop from a full FIFO
        waitFrames(base + 1, 200);
        g = frame_gap[base[5:0]];
        while (cyc < g + GAP) step();
        checkOutput("pre_pop_count", 32'(o_count), 4);
        i_data  = 8'h26;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        checkOutput("pop_write_count", 32'(o_count), 3);
        checkOutput("pop_write_full", 32'(o_full), 0);
        checkOutput("pop_write_start", 32'(o_ps2_data), 0);
        waitFrames(base + 5, 5 * 120);
        repeat (200) step();
        checkOutput("ovf_frames", frames_done - base, 5);
        checkOutput("ovf_sticky", 32'(o_overflow), 1);
        checkOutput("queue_empty", exp_q.size(), 0);

        // Reset 30 cycles into a 0x5A frame, then a clean 0xAA frame
        $display("[TB] reset mid-frame");
        waitIdle(50);
        base = frames_done;
        applyStimulus(8'h5A, 1'b1);
        step();
        h = cyc;
        while (cyc < h + 29) step();
        i_clr_n = 1'b0;
        step();
        checkOutput("mid_rst_clk", 32'(o_ps2_clk), 1);
        checkOutput("mid_rst_data", 32'(o_ps2_data), 1);
        checkOutput("mid_rst_count", 32'(o_count), 0);
        checkOutput("mid_rst_ovf", 32'(o_overflow), 0);
        checkOutput("mid_rst_busy", 32'(o_busy), 0);
        exp_q.delete();
        i_clr_n = 1'b1;
        step();
        checkOutput("rst_no_frame", frames_done, base);
        applyStimulus(8'hAA, 1'b1);
        waitFrames(base + 1, 200);
        checkOutput("bits_aa", 32'(frame_bits[base[5:0]]), 32'h754);
        waitIdle(50);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
